// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX-stage control and the iterative multiply/divide unit.
// Signal names match the original flat port list so existing connections map one-to-one.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, wr_hi, wr_lo, wdata,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, wr_hi, wr_lo, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: WIDTH shift-add or restoring shift-subtract steps
// on operand magnitudes, then one sign-fixup cycle that writes HI/LO and pulses done.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] hi_w_q, hi_w_d;
    logic [WIDTH-1:0] lo_w_q, lo_w_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        neg_a     = bus.op[0] & bus.A[WIDTH-1];
        neg_b     = bus.op[0] & bus.B[WIDTH-1];
        a_mag     = neg_a ? -bus.A : bus.A;
        b_mag     = neg_b ? -bus.B : bus.B;

        // hi_w:lo_w is the product shift register for mul, remainder:dividend for div.
        mul_sum   = {1'b0, hi_w_q} + {1'b0, (lo_w_q[0] ? b_mag_q : '0)};
        div_shift = {hi_w_q, lo_w_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};

        prod      = {hi_w_q, lo_w_q};
        prod_fix  = neg_res_q ? -prod : prod;
        quot_fix  = neg_res_q ? -lo_w_q : lo_w_q;
        rem_fix   = neg_rem_q ? -hi_w_q : hi_w_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_orig_d  = a_orig_q;
        b_mag_d   = b_mag_q;
        hi_w_d    = hi_w_q;
        lo_w_d    = lo_w_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_hi) hi_d = bus.wdata;
                if (bus.wr_lo) lo_d = bus.wdata;
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    div0_d    = (bus.B == '0);
                    a_orig_d  = bus.A;
                    b_mag_d   = b_mag;
                    hi_w_d    = '0;
                    lo_w_d    = a_mag;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Invariant remainder < divisor keeps the difference within WIDTH bits
                    // whenever there is no borrow.
                    if (!div_diff[WIDTH]) begin
                        hi_w_d = div_diff[WIDTH-1:0];
                        lo_w_d = {lo_w_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_w_d = div_shift[WIDTH-1:0];
                        lo_w_d = {lo_w_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_w_d = mul_sum[WIDTH:1];
                    lo_w_d = {mul_sum[0], lo_w_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_orig_q  <= '0;
            b_mag_q   <= '0;
            hi_w_q    <= '0;
            lo_w_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_orig_q  <= a_orig_d;
            b_mag_q   <= b_mag_d;
            hi_w_q    <= hi_w_d;
            lo_w_q    <= lo_w_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against
// an arithmetic reference model of HI/LO.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {HI, LO} from plain arithmetic on the original operands.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return 64'(a) * 64'(b);
            2'b01: return 64'(sa * sb);
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit wr_start, input bit wr_mid, input string tag);
        logic [63:0] exp;
        int cyc;
        int busy_n;
        bit got;
        exp = ref_model(o, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        if (wr_start) begin
            bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hA5A5_5A5A;
            model_hi = 32'hA5A5_5A5A; model_lo = 32'hA5A5_5A5A;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        bus.op = 2'($urandom); bus.A = $urandom; bus.B = $urandom;
        if (wr_start) begin
            check({tag, "_hi_wr_t0"}, bus.HI, model_hi);
            check({tag, "_lo_wr_t0"}, bus.LO, model_lo);
        end
        busy_n = (bus.busy === 1'b1) ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            bus.wr_hi = wr_mid && (cyc >= 2) && (cyc <= 4);
            bus.wr_lo = bus.wr_hi;
            bus.wdata = $urandom;
            @(posedge clk); #1;
            cyc++;
            if (wr_mid && cyc == 6) begin
                check({tag, "_hi_busy_wr"}, bus.HI, model_hi);
                check({tag, "_lo_busy_wr"}, bus.LO, model_lo);
            end
            if (bus.done === 1'b1) got = 1'b1;
            else if (bus.busy === 1'b1) busy_n++;
        end
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check({tag, "_hi"}, bus.HI, model_hi);
        check({tag, "_lo"}, bus.LO, model_lo);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_hi_hold"}, bus.HI, model_hi);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        int done_cyc;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_errors = 0;
        model_hi = '0;
        model_lo = '0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);

        run_op(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, "multu_ffff");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, "mult_neg");
        run_op(2'b10, 32'd7, 32'd2, 1'b0, 1'b0, "divu_7_2");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(2'b10, 32'h0000_00FF, 32'd0, 1'b0, 1'b0, "divu_by0");
        run_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "div_by0");

        // start retrigger and operand changes mid-run must not disturb MULTU 3x5
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd3; bus.B = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0; done_cyc = 0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == 5);
            bus.op = 2'b10;
            bus.A = $urandom; bus.B = $urandom;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
        end
        bus.start = 1'b0;
        model_hi = 32'd0; model_lo = 32'd15;
        check("retrig_ndone", 64'(ndone), 64'd1);
        check("retrig_done_cyc", 64'(done_cyc), 64'd33);
        check("retrig_hi", bus.HI, model_hi);
        check("retrig_lo", bus.LO, model_lo);
        check("retrig_busy_end", bus.busy, 1'b0);

        // reset mid-operation aborts with no done and cleared HI/LO
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd3; bus.B = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            rst = (cyc == 10);
            @(posedge clk); #1;
            if (cyc == 10) begin
                check("abort_busy", bus.busy, 1'b0);
                check("abort_hi", bus.HI, 32'd0);
                check("abort_lo", bus.LO, 32'd0);
            end
            if (bus.done === 1'b1) ndone++;
        end
        rst = 1'b0;
        model_hi = '0; model_lo = '0;
        check("abort_ndone", 64'(ndone), 64'd0);
        check("abort_hi_end", bus.HI, model_hi);
        check("abort_lo_end", bus.LO, model_lo);

        // MTHI/MTLO in IDLE
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.wr_hi = 1'b0;
        model_hi = 32'h1234_5678;
        check("mthi_hi", bus.HI, model_hi);
        check("mthi_lo", bus.LO, model_lo);
        @(negedge clk);
        bus.wr_lo = 1'b1; bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.wr_lo = 1'b0;
        model_lo = 32'hCAFE_F00D;
        check("mtlo_lo", bus.LO, model_lo);
        check("mtlo_hi", bus.HI, model_hi);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "busy_wr");
        run_op(2'b01, 32'h0000_1234, 32'hFFFF_0000, 1'b1, 1'b0, "start_wr");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
